// File: rtl/mon_date_set.sv
// mon_date_set: button edge detect, RUN/SET_MON/SET_DATE FSM, month/date calendar with BCD outputs
module mon_date_set #(
  parameter int FEB_DAYS = 28
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pb_mode_deb,
  input  logic       pb_inc_deb,
  input  logic       day_tick,
  output logic [3:0] month,
  output logic [4:0] date,
  output logic [7:0] month_bcd,
  output logic [7:0] date_bcd,
  output logic [1:0] set_mode
);
  typedef enum logic [1:0] {RUN = 2'b00, SET_MON = 2'b01, SET_DATE = 2'b10} state_t;
  state_t     state_q, state_d;
  logic [3:0] month_q, month_d;
  logic [4:0] date_q, date_d;
  logic       mode_prev_q, inc_prev_q, mode_pulse_q, inc_pulse_q;
  logic [3:0] nxt_m;
  function automatic logic [4:0] max_d(input logic [3:0] m);
    return (m == 4'd4 || m == 4'd6 || m == 4'd9 || m == 4'd11) ? 5'd30 :
           (m == 4'd2) ? 5'(FEB_DAYS) : 5'd31;
  endfunction
  function automatic logic [7:0] bcd(input logic [4:0] v);
    logic [3:0] t;
    t = (v >= 5'd30) ? 4'd3 : (v >= 5'd20) ? 4'd2 : (v >= 5'd10) ? 4'd1 : 4'd0;
    return {t, 4'(v - 5'(t) * 5'd10)};
  endfunction
  assign nxt_m = (month_q == 4'd12) ? 4'd1 : month_q + 4'd1;
  always_comb begin
    state_d = state_q;
    month_d = month_q;
    date_d  = date_q;
    case (state_q)
      RUN: begin
        if (day_tick) begin
          date_d  = (date_q < max_d(month_q)) ? date_q + 5'd1 : 5'd1;
          month_d = (date_q < max_d(month_q)) ? month_q : nxt_m;
        end
        if (mode_pulse_q) state_d = SET_MON;
      end
      SET_MON: begin
        if (mode_pulse_q) state_d = SET_DATE;
        else if (inc_pulse_q) begin
          month_d = nxt_m;
          date_d  = (date_q > max_d(nxt_m)) ? max_d(nxt_m) : date_q;
        end
      end
      SET_DATE: begin
        if (mode_pulse_q) state_d = RUN;
        else if (inc_pulse_q) date_d = (date_q < max_d(month_q)) ? date_q + 5'd1 : 5'd1;
      end
      default: state_d = RUN;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RUN;
      month_q      <= 4'd1;
      date_q       <= 5'd1;
      mode_prev_q  <= 1'b0;
      inc_prev_q   <= 1'b0;
      mode_pulse_q <= 1'b0;
      inc_pulse_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      month_q      <= month_d;
      date_q       <= date_d;
      mode_prev_q  <= pb_mode_deb;
      inc_prev_q   <= pb_inc_deb;
      mode_pulse_q <= pb_mode_deb & ~mode_prev_q;
      inc_pulse_q  <= pb_inc_deb & ~inc_prev_q;
    end
  end
  assign month     = month_q;
  assign date      = date_q;
  assign set_mode  = state_q;
  assign month_bcd = bcd({1'b0, month_q});
  assign date_bcd  = bcd(date_q);
endmodule
